// File: rtl/mem_fifo_ctrl.sv
// rtl/mem_fifo_ctrl.sv - FIFO controller around a 16x8 sync-read memory; optional ALMOST_FULL_EN adds the almost_full flag
module mem_fifo_ctrl #(
    parameter int DW       = 8,
    parameter int AW       = 4,
    parameter int AF_LEVEL = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW:0]   count,
    output logic          almost_full
);

    localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);
    localparam logic [AW:0] ONE   = (AW+1)'(1);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count_q;
    logic          rd_pending;
    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    logic          push;
    logic          pop;
    logic          issue;

    // Acceptance looks only at registered occupancy, so a same-cycle read never frees a slot early.
    assign in_ready = !rst && (count_q != DEPTH);
    assign push     = in_valid && in_ready;
    assign pop      = out_valid_q && out_ready;
    // A read may only start when the output register will be free by the time the byte returns.
    assign issue    = !rst && (count_q != '0) && !rd_pending && (!out_valid_q || pop);

    assign mem_we    = push;
    assign mem_waddr = wptr;
    assign mem_wdata = in_data;
    assign mem_re    = issue;
    assign mem_raddr = rptr;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign count     = count_q;

`ifdef ALMOST_FULL_EN
    localparam logic [AW:0] AF_THR = (AW+1)'(AF_LEVEL);
    assign almost_full = !rst && (count_q >= AF_THR);
`else
    assign almost_full = 1'b0;
`endif

    // Pointers, occupancy, read-pending flag and the registered output byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            count_q     <= '0;
            rd_pending  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (issue) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !issue) begin
                count_q <= count_q + ONE;
            end else if (!push && issue) begin
                count_q <= count_q - ONE;
            end
            rd_pending <= issue;
            if (rd_pending) begin
                out_data_q  <= mem_rdata;
                out_valid_q <= 1'b1;
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// tb/tb_mem_fifo_ctrl.sv - randomized self-checking bench for mem_fifo_ctrl against a queue-based model
module tb_mem_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       mem_we;
    logic [3:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       mem_re;
    logic [3:0] mem_raddr;
    logic [7:0] mem_rdata = 8'h00;
    logic [4:0] count;
    logic       almost_full;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_fifo_ctrl #(.DW(8), .AW(4), .AF_LEVEL(12)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .count(count), .almost_full(almost_full)
    );

    // Storage array the controller drives: synchronous write, one-cycle read latency.
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_raddr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes in memory as a queue, one byte in flight, one in the output register.
    logic [7:0] m_q[$];
    bit         m_pend = 0;
    logic [7:0] m_pend_data = 0;
    bit         m_ov = 0;
    logic [7:0] m_od = 0;
    int         m_wcnt = 0;
    int         m_rcnt = 0;
    bit         started = 0;
    int         cyc = 0;
    logic [7:0] pop_log[$];
    int         pop_cyc[$];

    function automatic bit e_ready();
        return !rst && (m_q.size() != 16);
    endfunction
    function automatic bit e_pop();
        return m_ov && out_ready;
    endfunction
    function automatic bit e_issue();
        return !rst && (m_q.size() != 0) && !m_pend && (!m_ov || e_pop());
    endfunction

    always @(posedge clk) begin
        bit p_push, p_pop, p_issue;
        cyc++;
        if (rst) begin
            m_q.delete();
            m_pend = 0; m_ov = 0; m_od = 0;
            m_wcnt = 0; m_rcnt = 0;
            started = 1;
        end else if (started) begin
            p_push  = in_valid && e_ready();
            p_pop   = e_pop();
            p_issue = e_issue();
            if (p_pop) begin
                pop_log.push_back(m_od);
                pop_cyc.push_back(cyc);
            end
            if (m_pend) begin
                m_od = m_pend_data;
                m_ov = 1;
            end else if (p_pop) begin
                m_ov = 0;
            end
            if (p_issue) begin
                m_pend_data = m_q.pop_front();
                m_rcnt++;
            end
            m_pend = p_issue;
            if (p_push) begin
                m_q.push_back(in_data);
                m_wcnt++;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model, away from the active edge.
    always @(negedge clk) begin
        bit x_push, x_issue;
        if (started) begin
            x_push  = in_valid && e_ready();
            x_issue = e_issue();
            chk("in_ready", in_ready, e_ready());
            chk("mem_we", mem_we, x_push);
            if (x_push) begin
                chk("mem_waddr", mem_waddr, m_wcnt % 16);
                chk("mem_wdata", mem_wdata, in_data);
            end
            chk("mem_re", mem_re, x_issue);
            if (x_issue) chk("mem_raddr", mem_raddr, m_rcnt % 16);
            chk("count", count, m_q.size());
            chk("out_valid", out_valid, m_ov);
            chk("out_data", out_data, m_od);
`ifdef ALMOST_FULL_EN
            chk("almost_full", almost_full, !rst && (m_q.size() >= 12));
`else
            chk("almost_full", almost_full, 0);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [7:0] first, input int n, input int max_cyc, output int got);
        got = 0;
        in_valid = 1;
        in_data = first;
        for (int c = 0; c < max_cyc && got < n; c++) begin
            @(negedge clk);
            if (in_ready) got++;
            step();
            in_data = 8'(first + got);
        end
        if (got == n) in_valid = 0;
    endtask

    task automatic wait_pops(input int target, input int max_cyc, input string name);
        int c;
        c = 0;
        while (pop_log.size() < target && c < max_cyc) begin
            step();
            c++;
        end
        chk(name, pop_log.size() >= target, 1);
    endtask

    initial begin
        int got;
        int base;
        rst = 1; in_valid = 1; in_data = 8'hA5; out_ready = 0;

        // Reset held two cycles with upstream valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_count", count, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_re", mem_re, 0);

        // Single byte through the pipeline.
        step();
        rst = 0; out_ready = 1;
        @(negedge clk);
        chk("single_we", mem_we, 1);
        chk("single_waddr", mem_waddr, 0);
        step();
        in_valid = 0;
        @(negedge clk);
        chk("single_re", mem_re, 1);
        chk("single_raddr", mem_raddr, 0);
        chk("single_count1", count, 1);
        step();
        @(negedge clk);
        chk("single_ov_early", out_valid, 0);
        step();
        @(negedge clk);
        chk("single_ov", out_valid, 1);
        chk("single_data", out_data, 8'hA5);
        chk("single_count0", count, 0);

        // Fill to full with downstream stalled: 16 in memory plus the output register.
        step();
        out_ready = 0;
        push_seq(8'h00, 17, 80, got);
        chk("fill_accepted", got, 17);
        in_valid = 1; in_data = 8'h11;
        repeat (5) step();
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        chk("full_count", count, 16);
`ifdef ALMOST_FULL_EN
        chk("full_almost_full", almost_full, 1);
`endif

        // Drain in order at one byte per two cycles.
        step();
        in_valid = 0; out_ready = 1;
        base = pop_log.size();
        wait_pops(base + 17, 100, "drain_done");
        for (int i = 0; i < 17; i++) chk("drain_order", pop_log[base + i], i);
        chk("drain_rate", pop_cyc[base + 16] - pop_cyc[base], 32);

        // Twenty more bytes across the pointer wrap with random handshakes.
        base = pop_log.size();
        got = 0;
        in_data = 8'h20;
        in_valid = 1'($urandom_range(0, 1));
        for (int c = 0; c < 300 && got < 20; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) got++;
            step();
            in_data = 8'(8'h20 + got);
            in_valid = (got < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 0; out_ready = 1;
        chk("wrap_accepted", got, 20);
        wait_pops(base + 20, 100, "wrap_drain_done");
        for (int i = 0; i < 20; i++) chk("wrap_order", pop_log[base + i], 8'h20 + i);

        // Simultaneous push and read issue at count 5.
        repeat (3) step();
        out_ready = 0;
        push_seq(8'h40, 6, 30, got);
        repeat (3) step();
        @(negedge clk);
        chk("c5_count", count, 5);
        chk("c5_out_valid", out_valid, 1);
        step();
        in_valid = 1; in_data = 8'h77; out_ready = 1;
        @(negedge clk);
        chk("both_we", mem_we, 1);
        chk("both_re", mem_re, 1);
        chk("both_addr_differ", mem_waddr != mem_raddr, 1);
        step();
        in_valid = 0; out_ready = 0;
        @(negedge clk);
        chk("both_count", count, 5);
        step();
        out_ready = 1;
        base = pop_log.size();
        wait_pops(base + 6, 60, "c5_drain_done");
        for (int i = 0; i < 5; i++) chk("c5_order", pop_log[base + i], 8'h41 + i);
        chk("c5_last", pop_log[base + 5], 8'h77);
        repeat (3) step();

        // Reset in the cycle after a read was issued.
        out_ready = 0; in_valid = 1; in_data = 8'h5A;
        step();
        in_valid = 0;
        @(negedge clk);
        chk("rmid_re", mem_re, 1);
        step();
        rst = 1;
        step();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rmid_out_valid", out_valid, 0);
            chk("rmid_count", count, 0);
            chk("rmid_out_data", out_data, 8'h00);
            step();
        end

        // Random traffic with occasional reset.
        for (int c = 0; c < 400; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = 8'($urandom);
            out_ready = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 0; in_valid = 0; out_ready = 1;
        repeat (40) step();
        @(negedge clk);
        chk("final_count", count, 0);
        chk("final_out_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
